// File: rtl/seq_mem_pkg.sv
// Package: seq_mem_pkg
// Purpose : Shared constants and types for the game-sequence memory.
//   SEQ_DATA_W - bits per stored symbol in the default build
//   SEQ_DEPTH  - maximum sequence length in the default build (power of two, >= 2)
//   symbol_t   - one stored symbol at the default width
//   seq_status_t - bundle of the status flags for observers that want one struct
package seq_mem_pkg;

  localparam int SEQ_DATA_W = 4;
  localparam int SEQ_DEPTH  = 16;

  typedef logic [SEQ_DATA_W-1:0] symbol_t;

  typedef struct packed {
    logic full;
    logic overflow;
    logic rd_last;
    logic rd_done;
  } seq_status_t;

endpackage : seq_mem_pkg

// File: rtl/seq_mem_store.sv
// Module : seq_mem_store
// Purpose: DEPTH x DATA_W symbol array with one synchronous write port and one
//          asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    in   1       rising-edge clock
//   we     in   1       write enable, wdata stored at waddr on the clock edge
//   waddr  in   ADDR_W  write index
//   wdata  in   DATA_W  write symbol
//   raddr  in   ADDR_W  read index
//   rdata  out  DATA_W  symbol at raddr, 0-cycle latency
module seq_mem_store #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : seq_mem_store

// File: rtl/seq_mem.sv
// Module : seq_mem
// Purpose: Game-sequence memory. The random generator appends one symbol per
//          round; the playback/compare FSM replays them in order through a
//          playback pointer. Tracks length, full and a sticky overflow flag.
// Configuration macro:
//   SEQ_MEM_REG_OUT_EN - when defined, rd_data/rd_last/rd_done are registered
//                        and show the previous cycle's read state.
// Ports:
//   clk          in   1        sole clock, rising edge
//   rst_n        in   1        synchronous active-low reset
//   clear        in   1        empty the sequence (len, pointer, overflow to 0)
//   append       in   1        store append_data at index len, len+1
//   append_data  in   DATA_W   symbol to append
//   rd_restart   in   1        playback pointer to 0
//   rd_next      in   1        advance playback pointer by 1 (saturates at len)
//   rd_data      out  DATA_W   symbol at playback pointer, 0 when rd_done
//   rd_last      out  1        pointer == len-1 and len != 0
//   rd_done      out  1        pointer == len
//   len          out  PTR_W+1  current length, 0..DEPTH
//   full         out  1        len == DEPTH
//   overflow     out  1        sticky: append attempted while full
//
// Handshake: every control input is a single-cycle strobe with no ready
// return; a strobe high at a rising edge is consumed on that edge, subject to
// the priorities rst_n > clear > append (write side) and
// clear > rd_restart > rd_next (read side).
module seq_mem
  import seq_mem_pkg::*;
#(
  parameter  int DATA_W = SEQ_DATA_W,
  parameter  int DEPTH  = SEQ_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              append,
  input  logic [DATA_W-1:0] append_data,
  input  logic              rd_restart,
  input  logic              rd_next,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_done,
  output logic [PTR_W:0]    len,
  output logic              full,
  output logic              overflow
);

  localparam int LEN_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_ptr_q;
  logic              overflow_q;

  logic              full_c;
  logic              do_write;
  logic              rd_done_c;
  logic              rd_last_c;
  logic [DATA_W-1:0] store_rdata;
  logic [DATA_W-1:0] rd_data_c;

  assign full_c   = (len_q == LEN_MAX);
  // Reset and clear both beat append, so nothing lands in storage on those edges.
  assign do_write = rst_n && !clear && append && !full_c;

  // ---------------------------------------------------------------------------
  // Length and overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else if (append) begin
      if (full_c) begin
        overflow_q <= 1'b1;
      end else begin
        len_q <= len_q + LEN_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Playback pointer. rd_next is judged against the current len, so a
  // same-cycle append does not let the pointer step past the old end; the
  // pointer therefore never exceeds len.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
    end else if (clear || rd_restart) begin
      rd_ptr_q <= '0;
    end else if (rd_next && (rd_ptr_q != len_q)) begin
      rd_ptr_q <= rd_ptr_q + LEN_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Only the low PTR_W bits address the array: a write only happens
  // when len < DEPTH, and a read at pointer == DEPTH is masked by rd_done.
  // ---------------------------------------------------------------------------
  seq_mem_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (do_write),
    .waddr (len_q[PTR_W-1:0]),
    .wdata (append_data),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (store_rdata)
  );

  // ---------------------------------------------------------------------------
  // Combinational read state
  // ---------------------------------------------------------------------------
  assign rd_done_c = (rd_ptr_q == len_q);
  assign rd_last_c = (len_q != '0) && (rd_ptr_q == (len_q - LEN_ONE));
  assign rd_data_c = rd_done_c ? '0 : store_rdata;

`ifdef SEQ_MEM_REG_OUT_EN
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_last_q;
  logic              rd_done_q;

  // One-cycle delayed view of the read state; reset matches an empty sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
      rd_done_q <= 1'b1;
    end else begin
      rd_data_q <= rd_data_c;
      rd_last_q <= rd_last_c;
      rd_done_q <= rd_done_c;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_last = rd_last_q;
  assign rd_done = rd_done_q;
`else
  assign rd_data = rd_data_c;
  assign rd_last = rd_last_c;
  assign rd_done = rd_done_c;
`endif

  assign len      = len_q;
  assign full     = full_c;
  assign overflow = overflow_q;

endmodule : seq_mem

// File: tb/tb_seq_mem.sv
// Testbench for seq_mem (default parameters). Directed steps with hand-computed
// expectations; replay of long sequences is checked against an expected queue.
// When SEQ_MEM_REG_OUT_EN is defined the read outputs are sampled one extra
// idle cycle later, and a few checks confirm the one-cycle lag itself.
module tb_seq_mem;
  import seq_mem_pkg::*;

  localparam int W = SEQ_DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         append;
  logic [W-1:0] append_data;
  logic         rd_restart;
  logic         rd_next;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic         rd_done;
  logic [4:0]   len;
  logic         full;
  logic         overflow;

  always #5 clk = ~clk;

  seq_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .append      (append),
    .append_data (append_data),
    .rd_restart  (rd_restart),
    .rd_next     (rd_next),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_done     (rd_done),
    .len         (len),
    .full        (full),
    .overflow    (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs applied #1 after an edge, consumed on the next edge,
  // outputs sampled #1 after that edge.
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    clear = 1'b0; append = 1'b0; append_data = '0;
    rd_restart = 1'b0; rd_next = 1'b0;
  endtask

  task automatic step(input logic c, input logic a, input logic [W-1:0] d,
                      input logic rs, input logic nx);
    clear = c; append = a; append_data = d; rd_restart = rs; rd_next = nx;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_append(input logic [W-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  // Let registered read outputs catch up before sampling them.
  task automatic rd_settle();
`ifdef SEQ_MEM_REG_OUT_EN
    @(posedge clk); #1;
`endif
  endtask

  task automatic chk_rd(input string tag, input logic [W-1:0] d,
                        input logic last, input logic done);
    rd_settle();
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    chk({tag, "_last"}, 32'(rd_last), 32'(last));
    chk({tag, "_done"}, 32'(rd_done), 32'(done));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] e;
    idle_inputs();

    // 1: reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(rd_done), 32'd1);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);

    // 2: append 3,7,A then replay
    do_append(4'h3);
    do_append(4'h7);
    do_append(4'hA);
    chk("t2_len", 32'(len), 32'd3);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk_rd("t2_p0", 4'h3, 1'b0, 1'b0);
`ifdef SEQ_MEM_REG_OUT_EN
    // 6: right after the advancing edge the registered output still shows 3
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t6_lag_data", 32'(rd_data), 32'h3);
    chk_rd("t2_p1", 4'h7, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t6_lag_last", 32'(rd_last), 32'd0);
    chk_rd("t2_p2", 4'hA, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t6_lag_done", 32'(rd_done), 32'd0);
    chk_rd("t2_end", 4'h0, 1'b0, 1'b1);
`else
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t2_p1", 4'h7, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t2_p2", 4'hA, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t2_end", 4'h0, 1'b0, 1'b1);
`endif
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t2_extra", 4'h0, 1'b0, 1'b1);
    chk("t2_len_hold", 32'(len), 32'd3);

    // 3: fill to 16, overflow, replay, clear
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_append(W'(i));
      exp_q.push_back(W'(i));
      if (i == 14) chk("t3_not_full15", 32'(full), 32'd0);
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_len16", 32'(len), 32'd16);
    chk("t3_ovf_pre", 32'(overflow), 32'd0);
    do_append(4'h5);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_len_hold", 32'(len), 32'd16);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      chk_rd($sformatf("t3_replay%0d", i), e, (i == 15), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    chk_rd("t3_replay_end", 4'h0, 1'b0, 1'b1);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t3_clr_len", 32'(len), 32'd0);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_full", 32'(full), 32'd0);
    chk_rd("t3_clr_rd", 4'h0, 1'b0, 1'b1);

    // 4: clear beats append; restart beats next
    step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    chk("t4_len", 32'(len), 32'd0);
    chk_rd("t4_empty", 4'h0, 1'b0, 1'b1);
    do_append(4'h1);
    do_append(4'h2);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t4_ptr1", 4'h2, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk_rd("t4_ptr0", 4'h1, 1'b0, 1'b0);

    // 5: reset mid-playback (rd_ptr=2, len=5)
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_append(W'(4 + i));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t5_ptr2", 4'h6, 1'b0, 1'b0);
    chk("t5_len5", 32'(len), 32'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_len", 32'(len), 32'd0);
    chk("t5_done", 32'(rd_done), 32'd1);
    chk("t5_data", 32'(rd_data), 32'd0);

    // Same-cycle append + rd_next: both take effect
    do_append(4'hC);
    chk_rd("t7_c", 4'hC, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'hD, 1'b0, 1'b1);
    chk("t7_len", 32'(len), 32'd2);
    chk_rd("t7_d", 4'hD, 1'b1, 1'b0);

    // Append while done with rd_next: pointer held at old len, then sees new symbol
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_rd("t8_done", 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'hE, 1'b0, 1'b1);
    chk_rd("t8_e", 4'hE, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seq_mem
